// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file command controller.
package regfile_pkg;

  localparam int REG_AW = 4;
  localparam int REG_N  = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_LI  = 3'd5,
    OP_MOV = 3'd6,
    OP_NOP = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU; c is carry for ADD, borrow for SUB, 0 otherwise.
module alu_simple
  import regfile_pkg::*;
#(
  parameter int N = REG_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] imm,
  input  op_t          op,
  output logic [N-1:0] y,
  output logic         c
);

  logic [N:0] sum;

  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[N-1:0];
        c   = sum[N];
      end
      OP_SUB: begin
        // Top bit of the widened difference is set exactly when a < b.
        sum = {1'b0, a} - {1'b0, b};
        y   = sum[N-1:0];
        c   = sum[N];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_LI:   y = imm;
      OP_MOV:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Command initiator for a 2R/1W register file: IDLE->READ->EXEC->WB, one command per 4 cycles.
// All outputs registered; cmd_ready is a decode of the state register.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int N  = REG_N,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [N-1:0]  cmd_imm,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [N-1:0]  rd1,
  input  logic [N-1:0]  rd2,
  output logic [AW-1:0] wa3,
  output logic [N-1:0]  wd3,
  output logic          we3,
  output logic          done,
  output logic          flag_z,
  output logic          flag_c
);

  state_t        state_q;
  op_t           op_q;
  logic [AW-1:0] rd_q;
  logic [N-1:0]  imm_q;
  logic [N-1:0]  a_q, b_q;
  logic [AW-1:0] ra1_q, ra2_q, wa3_q;
  logic [N-1:0]  wd3_q;
  logic          we3_q, done_q, flag_z_q, flag_c_q;

  logic [N-1:0]  alu_y;
  logic          alu_c;

  alu_simple #(.N(N)) u_alu (
    .a   (a_q),
    .b   (b_q),
    .imm (imm_q),
    .op  (op_q),
    .y   (alu_y),
    .c   (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      we3_q    <= 1'b0;
      done_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= op_t'(cmd_op);
            rd_q    <= cmd_rd;
            imm_q   <= cmd_imm;
            // Read addresses are loaded at accept so they are stable throughout READ.
            ra1_q   <= cmd_rs1;
            ra2_q   <= cmd_rs2;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          a_q     <= rd1;
          b_q     <= rd2;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (op_q != OP_NOP) begin
            wa3_q    <= rd_q;
            wd3_q    <= alu_y;
            we3_q    <= 1'b1;
            flag_z_q <= (alu_y == '0);
          end
          if (op_q == OP_ADD || op_q == OP_SUB) flag_c_q <= alu_c;
          done_q  <= 1'b1;
          state_q <= S_WB;
        end
        S_WB: begin
          we3_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign ra1       = ra1_q;
  assign ra2       = ra2_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign we3       = we3_q;
  assign done      = done_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench: regfile_ctrl driving a behavioural 16x8 register file.
module tb_regfile_ctrl;
  import regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] cmd_imm;
  logic [3:0] ra1, ra2, wa3;
  logic [7:0] rd1, rd2, wd3;
  logic       we3, done, flag_z, flag_c;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rf [16] = '{default: 8'h00};

  always #5 clk = ~clk;

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  regfile_ctrl #(.N(8), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wa3(wa3), .wd3(wd3), .we3(we3),
    .done(done), .flag_z(flag_z), .flag_c(flag_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    cmd_op  = 3'($urandom);
    cmd_rd  = 4'($urandom);
    cmd_rs1 = 4'($urandom);
    cmd_rs2 = 4'($urandom);
    cmd_imm = 8'($urandom);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Issue one command and check the whole WB beat and the return to IDLE.
  task automatic do_cmd(input string tag, input op_t op, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2, input logic [7:0] imm,
                        input logic exp_we, input logic [7:0] exp_wd,
                        input logic exp_z, input logic exp_c);
    wait_ready(tag);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    scramble();
    check({tag, "_ready_read"}, cmd_ready, 0);
    tick();
    check({tag, "_we_exec"}, we3, 0);
    tick();
    check({tag, "_we"}, we3, exp_we);
    check({tag, "_done"}, done, 1);
    if (exp_we) begin
      check({tag, "_wa3"}, wa3, rd);
      check({tag, "_wd3"}, wd3, exp_wd);
    end
    check({tag, "_z"}, flag_z, exp_z);
    check({tag, "_c"}, flag_c, exp_c);
    tick();
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_ready_t4"}, cmd_ready, 1);
    if (exp_we) check({tag, "_rf"}, rf[rd], exp_wd);
  endtask

  initial begin
    logic       we_seen;
    logic [12:0] ready_vec;
    int         acc_idx;
    logic [2:0] hs_op  [3];
    logic [3:0] hs_rd  [3];
    logic [3:0] hs_rs1 [3];
    logic [3:0] hs_rs2 [3];
    logic [7:0] hs_imm [3];
    logic [11:0] acc_cyc;

    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_we3", we3, 0);
    check("rst_done", done, 0);
    check("rst_flags", {flag_z, flag_c}, 0);
    check("rst_ra", {ra1, ra2}, 0);
    check("rst_wa3_wd3", {wa3, wd3}, 0);

    do_cmd("li_r1", OP_LI, 4'd1, 4'd0, 4'd0, 8'h05, 1, 8'h05, 0, 0);
    do_cmd("li_r2", OP_LI, 4'd2, 4'd0, 4'd0, 8'h03, 1, 8'h03, 0, 0);
    do_cmd("add_r3", OP_ADD, 4'd3, 4'd1, 4'd2, 8'h00, 1, 8'h08, 0, 0);

    do_cmd("li_ff", OP_LI, 4'd1, 4'd0, 4'd0, 8'hFF, 1, 8'hFF, 0, 0);
    do_cmd("li_01", OP_LI, 4'd2, 4'd0, 4'd0, 8'h01, 1, 8'h01, 0, 0);
    do_cmd("add_wrap", OP_ADD, 4'd4, 4'd1, 4'd2, 8'h00, 1, 8'h00, 1, 1);
    do_cmd("sub_borrow", OP_SUB, 4'd5, 4'd2, 4'd1, 8'h00, 1, 8'h02, 0, 1);

    // Reset covers the EXEC->WB edge and the one after: the write must be dropped.
    wait_ready("abort");
    cmd_op = OP_ADD; cmd_rd = 4'd11; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2; cmd_imm = 8'h00;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    we_seen = we3 | done;
    tick();
    we_seen |= we3 | done;
    rst = 1'b1;
    tick();
    we_seen |= we3 | done;
    tick();
    we_seen |= we3 | done;
    rst = 1'b0;
    check("abort_ready", cmd_ready, 1);
    check("abort_flags", {flag_z, flag_c}, 0);
    tick();
    we_seen |= we3 | done;
    check("abort_no_we_done", we_seen, 0);
    check("abort_rf11", rf[11], 8'h00);

    do_cmd("li_0f", OP_LI, 4'd1, 4'd0, 4'd0, 8'h0F, 1, 8'h0F, 0, 0);
    do_cmd("xor_self", OP_XOR, 4'd1, 4'd1, 4'd1, 8'h00, 1, 8'h00, 1, 0);
    do_cmd("mov_r6", OP_MOV, 4'd6, 4'd1, 4'd0, 8'h00, 1, 8'h00, 1, 0);
    do_cmd("sub_neg", OP_SUB, 4'd12, 4'd1, 4'd2, 8'h00, 1, 8'hFF, 0, 1);
    do_cmd("nop", OP_NOP, 4'd13, 4'd1, 4'd2, 8'h55, 0, 8'h00, 0, 1);
    check("nop_wa3_hold", wa3, 4'd12);
    check("nop_rf13", rf[13], 8'h00);

    // Back-to-back with cmd_valid held high; fields change right after each accept.
    hs_op[0] = OP_LI;  hs_rd[0] = 4'd7; hs_rs1[0] = 4'd0; hs_rs2[0] = 4'd0; hs_imm[0] = 8'h11;
    hs_op[1] = OP_LI;  hs_rd[1] = 4'd8; hs_rs1[1] = 4'd0; hs_rs2[1] = 4'd0; hs_imm[1] = 8'h22;
    hs_op[2] = OP_ADD; hs_rd[2] = 4'd9; hs_rs1[2] = 4'd7; hs_rs2[2] = 4'd8; hs_imm[2] = 8'hEE;
    wait_ready("hs");
    acc_idx = 0;
    acc_cyc = '0;
    ready_vec = '0;
    cmd_op = hs_op[0]; cmd_rd = hs_rd[0]; cmd_rs1 = hs_rs1[0]; cmd_rs2 = hs_rs2[0]; cmd_imm = hs_imm[0];
    cmd_valid = 1'b1;
    for (int c = 0; c < 13; c++) begin
      logic acc;
      ready_vec[c] = cmd_ready;
      acc = cmd_ready & cmd_valid;
      tick();
      if (acc) begin
        acc_cyc[c] = 1'b1;
        acc_idx++;
        if (acc_idx < 3) begin
          cmd_op = hs_op[acc_idx]; cmd_rd = hs_rd[acc_idx]; cmd_rs1 = hs_rs1[acc_idx];
          cmd_rs2 = hs_rs2[acc_idx]; cmd_imm = hs_imm[acc_idx];
        end else begin
          cmd_valid = 1'b0;
          scramble();
        end
      end
    end
    check("hs_ready_pattern", 32'(ready_vec), 32'h1111);
    check("hs_accept_cycles", 32'(acc_cyc), 32'h111);
    wait_ready("hs_end");
    check("hs_rf7", rf[7], 8'h11);
    check("hs_rf8", rf[8], 8'h22);
    check("hs_rf9", rf[9], 8'h33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Initiator that drives the 3-port register file (two read ports `ra1/rd1`, `ra2/rd2`; one write port `wa3/wd3/we3`).
- Accepts one command at a time over a valid/ready handshake.
- For each command it reads two source registers, performs a simple ALU operation and writes the result back through the write port.
- Sits between the instruction/command source and the register file. It is the first block that exercises the register file's write path end to end.

Parameters:
- N, 8, data width; must match the register file's N.
- AW, 4, register address width; 16 addressable registers.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  3  operation code.
- cmd_rd  in  AW  destination register.
- cmd_rs1  in  AW  source register 1.
- cmd_rs2  in  AW  source register 2.
- cmd_imm  in  N  immediate operand, used by LI.
- ra1  out  AW  register file read address 1.
- ra2  out  AW  register file read address 2.
- rd1  in  N  register file read data 1; combinational with ra1.
- rd2  in  N  register file read data 2; combinational with ra2.
- wa3  out  AW  register file write address.
- wd3  out  N  register file write data.
- we3  out  1  register file write enable; one-cycle pulse.
- done  out  1  one-cycle pulse when a command completes.
- flag_z  out  1  result was zero (last executed op).
- flag_c  out  1  carry/borrow of last ADD/SUB.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE; all command and operand registers clear to 0.
  - Outputs: ra1=ra2=wa3=0, wd3=0, we3=0, done=0, flag_z=0, flag_c=0, cmd_ready=1 in the cycle after reset.
  - Reset wins over every other event.
  - Reset mid-command aborts the command: no we3 pulse and no done.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at edge T, latch op/rd/rs1/rs2/imm, go to READ.
  - READ (cycle T+1): ra1=rs1, ra2=rs2. Capture rd1/rd2 into operand registers at edge. Go to EXEC.
  - EXEC (T+2): compute result into the result register; update flag_z, and flag_c where applicable. Go to WB.
  - WB (T+3): wa3=rd, wd3=result, we3=1 (0 for NOP), done=1. Go to IDLE.
- Handshake and throughput:
  - cmd_ready is high again at T+4; throughput is one command per 4 cycles.
  - Fields are sampled only at the accept edge. Later changes to cmd_* have no effect.
- ra1/ra2 hold their last value outside READ. wa3/wd3 hold their last value outside WB. we3 and done are 0 outside WB.
- Operations (all arithmetic mod 2^N):
  - 0 ADD: rs1+rs2; flag_c = bit N of the N+1-bit sum.
  - 1 SUB: rs1-rs2; flag_c = 1 when rs1<rs2 unsigned (borrow).
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 LI: result=imm.
  - 6 MOV: result=rs1.
  - 7 NOP: no write, flags unchanged, done still pulses.
- flag_c is unchanged by every op except ADD/SUB. flag_z is updated by ops 0-6.
- rd equal to rs1 or rs2 is legal: operands are captured before WB, so the old values are used.
- No hardwired zero register; register 0 is writable.

Decomposition:
- Shared package regfile_pkg:
  - op_t enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LI, OP_MOV, OP_NOP}.
  - state_t enum {S_IDLE, S_READ, S_EXEC, S_WB}.
  - Constants REG_AW=4, REG_N=8.
- Sub-module alu_simple: combinational, with ports a, b, imm, op → y, c. EXEC registers its outputs.
- Bench instantiates regfile_ctrl together with the register file.

Test Plan:
- Reset: assert rst for 2 cycles during WB of an ADD → we3 never pulses, next cycle cmd_ready=1, flags=0.
- Load and add:
  - LI r1←0x05, LI r2←0x03 → each shows we3 at accept+3 with wa3=1/2, wd3=0x05/0x03.
  - Then ADD r3←r1+r2 → wd3=0x08, flag_c=0, flag_z=0.
- Wrap and carry:
  - r1=0xFF, r2=0x01, ADD r4 → wd3=0x00, flag_c=1, flag_z=1.
  - SUB r5←r2-r1 → wd3=0x02, flag_c=1.
- Handshake: hold cmd_valid high with 3 back-to-back commands → accepts exactly at cycles 0, 4, 8; cmd_ready low in between; changing cmd_* after accept does not alter the result.
- Self-overwrite: r1=0x0F, XOR r1←r1^r1 → wd3=0x00 to wa3=1, flag_z=1; following MOV r6←r1 writes 0x00.
- NOP: done pulses at accept+3 with we3=0; flags retain their prior values.
